// File: rtl/rr_sel_arb.sv
// rr_sel_arb: 4-channel round-robin arbiter driving a 2-to-4 decoder (s = index, e = valid).
// All outputs are registered. Each tenure is followed by at least one e=0 bubble,
// so the decoded one-hot grant never jumps directly from one code to another.
// Optional tenure limit: define RR_SEL_ARB_TMO_EN to force a release after HOLD_MAX
// grant cycles. A forced release pulses tmo for one cycle.
module rr_sel_arb #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] s,
  output logic       e,
  output logic       busy,
  output logic       tmo
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] s_nxt;
  logic       e_nxt;
  logic [2:0] pick_res;

`ifdef RR_SEL_ARB_TMO_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tmo_q, tmo_nxt;
`endif

  // The result is {found, index}. Scanning starts just past the last winner,
  // so the most recent winner has the lowest priority.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic       found;
    logic [1:0] idx;
    logic [1:0] win;
    found = 1'b0;
    win   = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  assign pick_res = pick(req, ptr);

  // Compute the next state, grant index, valid flag, pointer and tenure counter.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    s_nxt     = s;
    e_nxt     = e;
`ifdef RR_SEL_ARB_TMO_EN
    cnt_nxt   = cnt;
    tmo_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        e_nxt = 1'b0;
        if (pick_res[2]) begin
          s_nxt     = pick_res[1:0];
          ptr_nxt   = pick_res[1:0];
          e_nxt     = 1'b1;
          state_nxt = GRANT;
`ifdef RR_SEL_ARB_TMO_EN
          cnt_nxt   = '0;
`endif
        end
      end
      GRANT: begin
        if (done || !req[s]) begin
          e_nxt     = 1'b0;
          state_nxt = IDLE;
        end
`ifdef RR_SEL_ARB_TMO_EN
        else if (cnt == HOLD_LAST) begin
          e_nxt     = 1'b0;
          state_nxt = IDLE;
          tmo_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      default: begin
        e_nxt     = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Register the state and outputs. Reset gives channel 0 first priority (ptr = 3).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'b11;
      s     <= 2'b00;
      e     <= 1'b0;
`ifdef RR_SEL_ARB_TMO_EN
      cnt   <= '0;
      tmo_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      s     <= s_nxt;
      e     <= e_nxt;
`ifdef RR_SEL_ARB_TMO_EN
      cnt   <= cnt_nxt;
      tmo_q <= tmo_nxt;
`endif
    end
  end

  assign busy = e;

`ifdef RR_SEL_ARB_TMO_EN
  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_rr_sel_arb.sv
// Testbench for rr_sel_arb: directed scenarios followed by random traffic.
// Outputs are compared against a tenure-level reference model.
module tb_rr_sel_arb;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] s;
  logic       e;
  logic       busy;
  logic       tmo;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: either a channel owns the grant, or nobody owns it.
  bit m_owned;
  int m_ch;
  int m_last;
  int m_held;
  bit m_tmo;
  int grants[$];

  rr_sel_arb #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .s(s), .e(e), .busy(busy), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge(input bit r, input logic [3:0] rq, input bit d);
`ifdef RR_SEL_ARB_TMO_EN
    bit tmo_on = 1'b1;
`else
    bit tmo_on = 1'b0;
`endif
    m_tmo = 1'b0;
    if (r) begin
      m_owned = 1'b0;
      m_ch    = 0;
      m_last  = 3;
    end else if (!m_owned) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (rq[c]) begin
          m_ch    = c;
          m_last  = c;
          m_owned = 1'b1;
          m_held  = 1;
          grants.push_back(c);
          break;
        end
      end
    end else begin
      if (d || !rq[m_ch]) begin
        m_owned = 1'b0;
      end else if (tmo_on && m_held == HOLD) begin
        m_owned = 1'b0;
        m_tmo   = 1'b1;
      end else begin
        m_held++;
      end
    end
  endfunction

  task automatic step(input bit r, input logic [3:0] rq, input bit d);
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    model_edge(r, rq, d);
    #1;
    chk("e", {3'b0, e}, {3'b0, m_owned});
    chk("busy", {3'b0, busy}, {3'b0, m_owned});
    chk("tmo", {3'b0, tmo}, {3'b0, m_tmo});
    chk("s", {2'b0, s}, 4'(m_ch));
  endtask

  initial begin
    logic [3:0] rq;
    int seen_e;
    rst = 1'b1; req = 4'b1111; done = 1'b0;
    m_owned = 0; m_ch = 0; m_last = 3; m_held = 0; m_tmo = 0;

    // Reset held for two edges with every channel requesting.
    step(1, 4'b1111, 0);
    step(1, 4'b1111, 0);
    chk("rst_s", {2'b0, s}, 4'h0);
    chk("rst_e", {3'b0, e}, 4'h0);
    // The first edge after reset grants channel 0.
    step(0, 4'b1111, 0);
    chk("first_grant_s", {2'b0, s}, 4'h0);
    chk("first_grant_e", {3'b0, e}, 4'h1);

    // Round robin: pulse done once per tenure.
    grants.delete();
    grants.push_back(0);
    for (int i = 0; i < 4; i++) begin
      step(0, 4'b1111, 1);
      chk("rr_bubble", {3'b0, e}, 4'h0);
      step(0, 4'b1111, 0);
    end
    chk("rr_len", 4'(grants.size()), 4'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("rr_order", 4'(grants[i]), 4'(i % 4));

    // Skip and wrap: channel 3 is granted next, then only channels 0 and 2 request.
    step(0, 4'b1111, 0);
    step(0, 4'b1111, 0);
    step(0, 4'b1111, 1);
    step(0, 4'b1000, 0);
    chk("wrap_ch3", {2'b0, s}, 4'h3);
    step(0, 4'b1000, 1);
    step(0, 4'b0101, 0);
    chk("wrap_ch0", {2'b0, s}, 4'h0);
    step(0, 4'b0101, 1);
    step(0, 4'b0101, 0);
    chk("skip_ch2", {2'b0, s}, 4'h2);

    // Release by dropping the request.
    step(0, 4'b0100, 0);
    step(0, 4'b0000, 0);
    chk("drop_e", {3'b0, e}, 4'h0);
    step(0, 4'b0100, 0);
    step(0, 4'b0010, 1);
    chk("done_wins", {3'b0, e}, 4'h0);
    step(0, 4'b0010, 0);
    chk("after_done_s", {2'b0, s}, 4'h1);
    chk("after_done_e", {3'b0, e}, 4'h1);

    // Reset during a grant to channel 1.
    step(1, 4'b1111, 0);
    chk("mid_rst_e", {3'b0, e}, 4'h0);
    step(0, 4'b1111, 0);
    chk("mid_rst_next", {2'b0, s}, 4'h0);
    step(0, 4'b0000, 0);

    // Single long request: bounded by HOLD when the limit is built in, unbounded otherwise.
    seen_e = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, 4'b0001, 0);
      if (e) seen_e++;
    end
`ifdef RR_SEL_ARB_TMO_EN
    chk("hold_cycles", 4'(seen_e), 4'(14 - 14 / (HOLD + 1)));
`else
    chk("hold_cycles", 4'(seen_e), 4'd14);
`endif
    step(0, 4'b0000, 0);

    // Random traffic.
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) < 2), rq, ($urandom_range(0, 99) < 20));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_sel_arb.md
Name: rr_sel_arb

Overview:
- 4-channel round-robin arbiter that sits directly upstream of the 2-to-4 decoder `dec`.
- It drives the decoder's `s[1:0]` (grant index) and `e` (grant valid), so `dec.y` becomes the one-hot grant vector.
- Requesters assert a line in `req` and hold it until served; the granted channel ends its tenure with `done` or by dropping its request.
- Sequential: registered outputs, IDLE/GRANT FSM, rotating priority pointer, tenure counter.

Parameters:
- HOLD_MAX, 16: maximum consecutive grant cycles per tenure (used only with the optional feature); legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the tenure counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per channel; bit i = channel i.
- done  input  1  granted channel releases the grant; sampled only in GRANT.
- s  output  2  grant index; connects to `dec.s`.
- e  output  1  grant valid; connects to `dec.e`.
- busy  output  1  high while FSM is in GRANT (equal to e).
- tmo  output  1  one-cycle pulse on forced release; constant 0 when the feature is compiled out.

Behaviour:
- One clock. Reset is synchronous and active-high: rst sampled high on a clk rising edge resets all state, overriding all other inputs.
- Reset values:
  - s=2'b00, e=0, busy=0, tmo=0.
  - state=IDLE, counter=0.
  - ptr=2'b11, so channel 0 has first priority after reset.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE state:
  - If req != 0 at an edge, select the first set bit scanning ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
  - At that same edge: s<=winner, e<=1, ptr<=winner, state<=GRANT, counter<=0.
  - Latency: e rises on the first edge at which req is seen nonzero.
  - If req == 0: remain in IDLE, e=0, s holds its last value.
- GRANT state:
  - s is stable for the whole tenure.
  - Release occurs at an edge where done=1 OR req[s]=0.
  - On release: e<=0, state<=IDLE.
  - Every tenure ends with at least one e=0 cycle before the next grant. This bubble is mandatory so `dec.y` never glitches between two one-hot codes.
- Simultaneous events:
  - done=1 together with new requests: the release wins. Arbitration happens at the next edge from IDLE, using the updated ptr.
  - done in IDLE is ignored.
  - Changes to req bits of other channels during GRANT have no effect.
- Fairness: with all 4 requests held continuously, grants rotate 0,1,2,3,0,...
- Wrap-around: ptr=3 with winner search wraps to channel 0.
- Reset mid-GRANT: e drops at that edge; the next grant starts again from channel 0 priority.
- busy mirrors e exactly.

Optional Feature:
- Macro: RR_SEL_ARB_TMO_EN.
- Defined:
  - In GRANT, counter increments every cycle without release.
  - When e has been high for HOLD_MAX cycles, that edge forces a release: e<=0, state<=IDLE, and tmo=1 for exactly one cycle.
  - ptr advances normally, so the offender loses priority.
  - done/req release on the same edge as a forced release: treated as a normal release, tmo=0.
- Not defined: no counter logic is built, tmo is tied 0, and tenure length is unbounded.

Test Plan:
- Reset: rst=1 for 2 edges with req=4'b1111 → s=00, e=0, busy=0, tmo=0. After rst=0, the next edge gives s=00, e=1, so `dec.y`=0001.
- Round-robin: req=4'b1111 held; pulse done for 1 cycle each tenure → grant sequence 00,01,10,11,00 with e low for one cycle between grants.
- Skip and wrap: grant ch3, release; then req=4'b0101 → next grant s=00, then s=10; ch1 and ch3 are never granted.
- Release by drop: grant ch2 with done=0; deassert req[2] → e falls at that edge. Simultaneous done=1 with req=4'b0010 → e=0 for one cycle, then s=01, e=1.
- Reset mid-grant: ptr=1 with ch1 granted, rst=1 for 1 edge with req=4'b1111 → e=0. Next grant is s=00.
- With RR_SEL_ARB_TMO_EN and HOLD_MAX=4: req=4'b0001 held, done=0 → e high exactly 4 cycles, tmo pulses 1 cycle as e falls, one idle cycle, then ch0 re-granted. Without the macro → e stays high indefinitely and tmo=0.
